// File: rtl/fpu_fp80_to_int32.sv
// x87 80-bit extended real to signed int32 converter (FIST m32int path).
// Four-stage unpack/align/round pipeline FSM with enable/done handshake.
module fpu_fp80_to_int32 #(
    parameter logic [31:0] INT_INDEFINITE = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [79:0] fp_in,
    input  logic [1:0]  round_mode,
    output logic [31:0] int_out,
    output logic        done,
    output logic        flag_invalid,
    output logic        flag_inexact
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_ALIGN,
        S_ROUND,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [79:0]        fp_q;
    logic [1:0]         rc_q;
    logic signed [16:0] e_q;
    logic               inv_q;
    logic [31:0]        mag_q;
    logic               rnd_q;
    logic               stk_q;
    logic [31:0]        int_out_q;
    logic               inv_out_q;
    logic               inx_out_q;

    logic               sign_w;
    logic [14:0]        exp_w;
    logic [63:0]        mant_w;
    logic signed [16:0] e_w;
    logic               cls_inv_w;
    logic [6:0]         sh_w;
    logic [95:0]        wide_w;
    logic [31:0]        al_int_w;
    logic               al_rnd_w;
    logic               al_stk_w;
    logic               inc_w;
    logic [32:0]        mag_w;
    logic               rng_inv_w;
    logic               res_inv_w;
    logic [31:0]        res_int_w;
    logic               res_inx_w;

    assign sign_w = fp_q[79];
    assign exp_w  = fp_q[78:64];
    assign mant_w = fp_q[63:0];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (enable) state_d = S_UNPACK;
            S_UNPACK: state_d = S_ALIGN;
            S_ALIGN:  state_d = S_ROUND;
            S_ROUND:  state_d = S_DONE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        e_w       = $signed({2'b00, exp_w}) - 17'sd16383;
        cls_inv_w = (exp_w == 15'h7FFF)
                  | ((exp_w != 15'd0) & ~mant_w[63])
                  | (e_w > 17'sd31);
    end

    // Shift is only meaningful for -1 <= e <= 31 (63-e in 32..64); wraps otherwise.
    always_comb begin
        sh_w   = 7'd63 - e_q[6:0];
        wide_w = 96'({mant_w, 64'd0} >> sh_w);
        if (e_q < -17'sd1) begin
            al_int_w = 32'd0;
            al_rnd_w = 1'b0;
            al_stk_w = |mant_w;
        end else begin
            al_int_w = wide_w[95:64];
            al_rnd_w = wide_w[63];
            al_stk_w = |wide_w[62:0];
        end
    end

    always_comb begin
        inc_w = 1'b0;
        unique case (rc_q)
            2'b00: inc_w = rnd_q & (stk_q | mag_q[0]);
            2'b01: inc_w = sign_w & (rnd_q | stk_q);
            2'b10: inc_w = ~sign_w & (rnd_q | stk_q);
            default: inc_w = 1'b0;
        endcase
        mag_w     = {1'b0, mag_q} + {32'd0, inc_w};
        rng_inv_w = sign_w ? (mag_w > 33'h0_8000_0000)
                           : (mag_w > 33'h0_7FFF_FFFF);
        res_inv_w = inv_q | rng_inv_w;
        res_inx_w = ~res_inv_w & (rnd_q | stk_q);
        if (res_inv_w) begin
            res_int_w = INT_INDEFINITE;
        end else if (sign_w) begin
            res_int_w = 32'd0 - mag_w[31:0];
        end else begin
            res_int_w = mag_w[31:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            fp_q      <= 80'd0;
            rc_q      <= 2'b00;
            e_q       <= 17'sd0;
            inv_q     <= 1'b0;
            mag_q     <= 32'd0;
            rnd_q     <= 1'b0;
            stk_q     <= 1'b0;
            int_out_q <= 32'd0;
            inv_out_q <= 1'b0;
            inx_out_q <= 1'b0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                S_IDLE: begin
                    if (enable) begin
                        fp_q <= fp_in;
                        rc_q <= round_mode;
                    end
                end
                S_UNPACK: begin
                    e_q   <= e_w;
                    inv_q <= cls_inv_w;
                end
                S_ALIGN: begin
                    mag_q <= al_int_w;
                    rnd_q <= al_rnd_w;
                    stk_q <= al_stk_w;
                end
                S_ROUND: begin
                    int_out_q <= res_int_w;
                    inv_out_q <= res_inv_w;
                    inx_out_q <= res_inx_w;
                end
                default: ;
            endcase
        end
    end

    assign done         = (state_q == S_DONE);
    assign int_out      = int_out_q;
    assign flag_invalid = inv_out_q;
    assign flag_inexact = inx_out_q;

endmodule

// File: tb/tb_fpu_fp80_to_int32.sv
// Directed-vector bench for fpu_fp80_to_int32.
// Checks latency, result, flags, enable-ignore and mid-op reset.
module tb_fpu_fp80_to_int32;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [79:0] fp_in;
    logic [1:0]  round_mode;
    logic [31:0] int_out;
    logic        done;
    logic        flag_invalid;
    logic        flag_inexact;

    int total = 0;
    int bad   = 0;

    fpu_fp80_to_int32 dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .fp_in        (fp_in),
        .round_mode   (round_mode),
        .int_out      (int_out),
        .done         (done),
        .flag_invalid (flag_invalid),
        .flag_inexact (flag_inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [79:0] v, input logic [1:0] rc);
        @(negedge clk);
        fp_in      = v;
        round_mode = rc;
        enable     = 1'b1;
        @(posedge clk);
        #1;
        enable     = 1'b0;
    endtask

    task automatic run(input string tag, input logic [79:0] v,
                       input logic [1:0] rc, input logic [31:0] exp_int,
                       input logic exp_inv, input logic exp_inx);
        int k;
        start(v, rc);
        k = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                k = i + 1;
                break;
            end
        end
        check({tag, ".latency"}, k, 4);
        check({tag, ".int"}, int_out, exp_int);
        check({tag, ".inv"}, {31'd0, flag_invalid}, {31'd0, exp_inv});
        check({tag, ".inx"}, {31'd0, flag_inexact}, {31'd0, exp_inx});
        @(posedge clk);
        #1;
        check({tag, ".pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int n;
        reset      = 1'b1;
        enable     = 1'b0;
        fp_in      = 80'd0;
        round_mode = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        check("rst.int", int_out, 32'd0);
        check("rst.done", {31'd0, done}, 32'd0);
        check("rst.flags", {30'd0, flag_invalid, flag_inexact}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run("two",    80'h4000_8000000000000000, 2'b00, 32'h0000_0002, 0, 0);
        run("three",  80'h4000_C000000000000000, 2'b00, 32'h0000_0003, 0, 0);
        run("p15rn",  80'h3FFF_C000000000000000, 2'b00, 32'h0000_0002, 0, 1);
        run("p15ch",  80'h3FFF_C000000000000000, 2'b11, 32'h0000_0001, 0, 1);
        run("p25rn",  80'h4000_A000000000000000, 2'b00, 32'h0000_0002, 0, 1);
        run("m25up",  80'hC000_A000000000000000, 2'b10, 32'hFFFF_FFFE, 0, 1);
        run("m3",     80'hC000_C000000000000000, 2'b00, 32'hFFFF_FFFD, 0, 0);
        run("m2p31",  80'hC01E_8000000000000000, 2'b00, 32'h8000_0000, 0, 0);
        run("p2p31",  80'h401E_8000000000000000, 2'b00, 32'h8000_0000, 1, 0);
        run("p2p32",  80'h401F_8000000000000000, 2'b11, 32'h8000_0000, 1, 0);
        run("ovfrn",  80'h401D_FFFFFFFF00000000, 2'b00, 32'h8000_0000, 1, 0);
        run("maxch",  80'h401D_FFFFFFFF00000000, 2'b11, 32'h7FFF_FFFF, 0, 1);
        run("qnan",   80'h7FFF_C000000000000000, 2'b00, 32'h8000_0000, 1, 0);
        run("inf",    80'h7FFF_8000000000000000, 2'b00, 32'h8000_0000, 1, 0);
        run("unnorm", 80'h4000_4000000000000000, 2'b00, 32'h8000_0000, 1, 0);
        run("mhalfn", 80'hBFFE_8000000000000000, 2'b00, 32'h0000_0000, 0, 1);
        run("mhalfd", 80'hBFFE_8000000000000000, 2'b01, 32'hFFFF_FFFF, 0, 1);
        run("denup",  80'h0000_0000000000000001, 2'b10, 32'h0000_0001, 0, 1);
        run("negz",   80'h8000_0000000000000000, 2'b01, 32'h0000_0000, 0, 0);

        start(80'h4000_C000000000000000, 2'b00);
        n = 0;
        @(posedge clk);
        #1;
        @(negedge clk);
        fp_in  = 80'h4000_8000000000000000;
        enable = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done) n++;
            @(posedge clk);
            #1;
        end
        check("ign.count", n, 1);
        check("ign.int", int_out, 32'h0000_0003);

        start(80'h3FFF_C000000000000000, 2'b00);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (done) n++;
        end
        check("rstmid.done", n, 0);
        check("rstmid.int", int_out, 32'd0);
        check("rstmid.flags", {30'd0, flag_invalid, flag_inexact}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run("after",  80'hC000_C000000000000000, 2'b00, 32'hFFFF_FFFD, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
